// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage types and constants
// INSTR_FETCH_MISALIGN_TRAP_EN adds the TRAP state.
package riscv_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
        , TRAP = 2'd2
`endif
    } fetch_state_e;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_INSTR      = 32'h0000_0000;
    localparam logic [31:0] FETCH_STRIDE     = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - 2-entry in-order buffer with synchronous flush
module fetch_fifo #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - in-order instruction fetch with redirect drain
// INSTR_FETCH_MISALIGN_TRAP_EN adds misalign_o and a terminal TRAP state.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [6:0]  opCode_o,
    output logic [2:0]  funct3_o,
    output logic [6:0]  funct7_o
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign_o
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fpc_q, fpc_d;
    logic [1:0]   out_q, out_d;
    logic [1:0]   disc_q, disc_d;
    logic [31:0]  redirect_target;
    logic [31:0]  rsp_pc;
    logic         gnt_acc, rsp_acc;
    logic         fifo_push, fifo_pop, fifo_valid;
    logic [63:0]  fifo_head;
    logic [1:0]   fifo_count;

`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    assign redirect_target = redirect_pc_i;
`else
    assign redirect_target = redirect_pc_i & 32'hFFFF_FFFC;
`endif

    assign imem_req_o  = !rst && (state_q == FETCH)
                         && (({1'b0, out_q} + {1'b0, fifo_count}) < 3'd2);
    assign imem_addr_o = fpc_q;
    assign gnt_acc     = imem_req_o && imem_gnt_i;
    // Responses with nothing outstanding belong to pre-reset requests.
    assign rsp_acc     = imem_rvalid_i && (state_q == FETCH) && (out_q != 2'd0);
    // Outstanding requests are sequential from the last redirect, so the oldest sits out_q words back.
    assign rsp_pc      = fpc_q - {28'd0, out_q, 2'b00};
    assign fifo_push   = rsp_acc && !redirect_i;
    assign fifo_pop    = instr_valid_o && instr_ready_i;

    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        out_d   = out_q;
        disc_d  = disc_q;
        case (state_q)
            FETCH: begin
                out_d = out_q + {1'b0, gnt_acc} - {1'b0, rsp_acc};
                if (gnt_acc) begin
                    fpc_d = fpc_q + FETCH_STRIDE;
                end
                if (redirect_i) begin
                    fpc_d  = redirect_target;
                    disc_d = out_d;
                    out_d  = 2'd0;
                    if (disc_d != 2'd0) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (imem_rvalid_i && (disc_q != 2'd0)) begin
                    disc_d = disc_q - 2'd1;
                end
                if (redirect_i) begin
                    fpc_d = redirect_target;
                end
                if (disc_d == 2'd0) begin
                    state_d = FETCH;
                end
            end
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
            TRAP: begin
                state_d = TRAP;
            end
`endif
            default: begin
                state_d = FETCH;
            end
        endcase
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
        if ((state_d == FETCH) && (fpc_d[1:0] != 2'b00)) begin
            state_d = TRAP;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            fpc_q   <= RESET_PC;
            out_q   <= 2'd0;
            disc_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
        end
    end

    fetch_fifo #(
        .WIDTH(64)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (redirect_i),
        .push_i     (fifo_push),
        .push_data_i({imem_rdata_i, rsp_pc}),
        .pop_i      (fifo_pop),
        .valid_o    (fifo_valid),
        .data_o     (fifo_head),
        .count_o    (fifo_count)
    );

    assign instr_valid_o = fifo_valid && !rst;
    assign instr_o       = rst ? RESET_INSTR : fifo_head[63:32];
    assign pc_o          = rst ? RESET_PC_DEFAULT : fifo_head[31:0];
    assign opCode_o      = instr_o[OPCODE_MSB:OPCODE_LSB];
    assign funct3_o      = instr_o[FUNCT3_MSB:FUNCT3_LSB];
    assign funct7_o      = instr_o[FUNCT7_MSB:FUNCT7_LSB];

`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    assign misalign_o = !rst && (state_q == TRAP);
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch
// INSTR_FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect trap vector.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [6:0]  opCode_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .opCode_o     (opCode_o),
        .funct3_o     (funct3_o),
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
        .funct7_o     (funct7_o),
        .misalign_o   (misalign_o)
`else
        .funct7_o     (funct7_o)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_addr_q [$];
    logic [63:0] exp_instr_q [$];
    logic [31:0] rq_addr [$];
    int          rq_due [$];
    int          cyc = 0;
    int          grants = 0;
    int          gnt_limit = 0;
    logic        rsp_hold = 1'b0;
    int          due_tmp;
    logic [63:0] mon_e;
    int          g0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0020_81B3;
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (exp_addr_q.size() == 0 && exp_instr_q.size() == 0) break;
        end
        n_cmp++;
        if (exp_addr_q.size() != 0 || exp_instr_q.size() != 0) begin
            n_fail++;
            $display("FAIL idle_timeout: got %0d addr / %0d instr pending, required 0 / 0",
                     exp_addr_q.size(), exp_instr_q.size());
        end
        tick(3);
    endtask

    // Memory: grants up to gnt_limit, answers one cycle after grant unless held.
    always @(negedge clk) begin
        #1;
        cyc = cyc + 1;
        imem_rvalid_i = 1'b0;
        if (!rsp_hold && rq_addr.size() > 0 && rq_due[0] <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(rq_addr.pop_front());
            due_tmp       = rq_due.pop_front();
        end
        imem_gnt_i = (grants < gnt_limit);
        if (imem_req_o && imem_gnt_i) begin
            grants++;
            rq_addr.push_back(imem_addr_o);
            rq_due.push_back(cyc + 1);
            if (exp_addr_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_req: got addr %h, required no request", imem_addr_o);
            end else begin
                check("req_addr", imem_addr_o, exp_addr_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst && instr_valid_o && instr_ready_i) begin
            if (exp_instr_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_instr: got pc %h instr %h, required none", pc_o, instr_o);
            end else begin
                mon_e = exp_instr_q.pop_front();
                check("pc_o", pc_o, mon_e[31:0]);
                check("instr_o", instr_o, mon_e[63:32]);
                check("opCode_o", 32'(opCode_o), 32'(mon_e[38:32]));
                check("funct3_o", 32'(funct3_o), 32'(mon_e[46:44]));
                check("funct7_o", 32'(funct7_o), 32'(mon_e[63:57]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        tick(3);
        #3;
        check("rst_req", 32'(imem_req_o), 32'h0);
        check("rst_valid", 32'(instr_valid_o), 32'h0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_pc", pc_o, 32'h0);
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
        check("rst_misalign", 32'(misalign_o), 32'h0);
`endif

        // Straight-line fetch of 0, 4, 8 with decode always ready.
        @(negedge clk);
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h8);
        exp_instr_q.push_back({32'h0020_81B3, 32'h0});
        exp_instr_q.push_back({32'hC0DE_0004, 32'h4});
        exp_instr_q.push_back({32'hC0DE_0008, 32'h8});
        instr_ready_i = 1'b1;
        gnt_limit = grants + 3;
        rst = 1'b0;
        wait_idle(60);

        // Decode stalled: only two fetches fit in flight plus buffer.
        rst = 1'b1;
        instr_ready_i = 1'b0;
        tick(2);
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        g0 = grants;
        gnt_limit = grants + 10;
        rst = 1'b0;
        tick(10);
        #3;
        check("stall_grants", 32'(grants - g0), 32'd2);
        check("stall_req", 32'(imem_req_o), 32'h0);
        check("stall_valid", 32'(instr_valid_o), 32'h1);
        check("stall_head_pc", pc_o, 32'h0);
        check("stall_head_instr", instr_o, 32'h0020_81B3);
        @(negedge clk);
        gnt_limit = grants;
        exp_instr_q.push_back({32'h0020_81B3, 32'h0});
        exp_instr_q.push_back({32'hC0DE_0004, 32'h4});
        instr_ready_i = 1'b1;
        wait_idle(40);

        // Redirect with two requests outstanding.
        rsp_hold = 1'b1;
        exp_addr_q.push_back(32'h8);
        exp_addr_q.push_back(32'hC);
        gnt_limit = grants + 2;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (grants >= gnt_limit) break;
        end
        check("pre_redirect_grants", 32'(grants), 32'(gnt_limit));
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        @(negedge clk);
        redirect_i = 1'b0;
        rsp_hold = 1'b0;
        exp_addr_q.push_back(32'h100);
        exp_instr_q.push_back({32'hC0DE_0100, 32'h100});
        gnt_limit = grants + 1;
        #3;
        check("drain_req", 32'(imem_req_o), 32'h0);
        wait_idle(40);

        // Redirect in the same cycle as a grant.
        rsp_hold = 1'b1;
        exp_addr_q.push_back(32'h104);
        gnt_limit = grants + 1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        @(negedge clk);
        redirect_i = 1'b0;
        rsp_hold = 1'b0;
        exp_addr_q.push_back(32'h200);
        exp_instr_q.push_back({32'hC0DE_0200, 32'h200});
        gnt_limit = grants + 1;
        #3;
        check("gnt_redirect_drain_req", 32'(imem_req_o), 32'h0);
        wait_idle(40);

        // Fetch address wraps from the top of the address space.
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_i = 1'b0;
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'h0);
        exp_instr_q.push_back({32'hC0DE_FFFC, 32'hFFFF_FFFC});
        exp_instr_q.push_back({32'h0020_81B3, 32'h0});
        gnt_limit = grants + 2;
        wait_idle(40);

        // Response to a pre-reset request must not surface.
        rsp_hold = 1'b1;
        exp_addr_q.push_back(32'h4);
        gnt_limit = grants + 1;
        tick(2);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        rsp_hold = 1'b0;
        tick(4);
        #3;
        check("stale_valid", 32'(instr_valid_o), 32'h0);
        @(negedge clk);
        exp_addr_q.push_back(32'h0);
        exp_instr_q.push_back({32'h0020_81B3, 32'h0});
        gnt_limit = grants + 1;
        wait_idle(40);

`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0102;
        @(negedge clk);
        redirect_i = 1'b0;
        g0 = grants;
        gnt_limit = grants + 5;
        tick(5);
        #3;
        check("trap_misalign", 32'(misalign_o), 32'h1);
        check("trap_req", 32'(imem_req_o), 32'h0);
        check("trap_grants", 32'(grants - g0), 32'h0);
        @(negedge clk);
        gnt_limit = grants;
        rst = 1'b1;
        tick(2);
        #3;
        check("trap_rst_misalign", 32'(misalign_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick(2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port redirect_i, input, 1 bit: branch/jump taken; load redirect_pc_i.
REQ-005 SHALL have port redirect_pc_i, input, 32 bits: redirect target address.
REQ-006 SHALL have port imem_req_o, output, 1 bit: instruction-memory request.
REQ-007 SHALL have port imem_addr_o, output, 32 bits: request address.
REQ-008 SHALL have port imem_gnt_i, input, 1 bit: request accepted this cycle.
REQ-009 SHALL have port imem_rvalid_i, input, 1 bit: read data valid; responses return in request order.
REQ-010 SHALL have port imem_rdata_i, input, 32 bits: instruction word.
REQ-011 SHALL have port instr_valid_o, output, 1 bit: instruction available to decode.
REQ-012 SHALL have port instr_ready_i, input, 1 bit: decode consumes the instruction.
REQ-013 SHALL have port instr_o, output, 32 bits: full instruction word.
REQ-014 SHALL have port pc_o, output, 32 bits: address of instr_o.
REQ-015 SHALL have ports opCode_o (7 bits), funct3_o (3 bits) and funct7_o (7 bits), all outputs, equal to instr_o[6:0], [14:12] and [31:25], feeding the control unit.

Function
REQ-016 SHALL keep fetch PC register fpc; imem_addr_o = fpc.
REQ-017 SHALL assert imem_req_o in FETCH only when outstanding + buffered < 2.
REQ-018 SHALL hold imem_req_o and imem_addr_o stable until imem_gnt_i.
REQ-019 SHALL, on grant, set fpc to fpc+4 (32-bit wrap: 32'hFFFF_FFFC -> 0) and increment outstanding.
REQ-020 SHALL, on imem_rvalid_i, push {rdata, request pc} into a 2-entry in-order FIFO and decrement outstanding.
REQ-021 SHALL present the FIFO head on instr_o and pc_o; instr_valid_o is high when the FIFO is not empty; latency from rvalid to instr_valid_o is 1 cycle.
REQ-022 SHALL pop the FIFO when instr_valid_o && instr_ready_i; push and pop in the same cycle keep the count unchanged.
REQ-023 SHALL use FSM states FETCH and DRAIN.
REQ-024 SHALL, on redirect_i: flush the FIFO, set fpc = redirect_pc_i, set discard = outstanding (counting a grant in the same cycle), and go to DRAIN if discard > 0, else stay in FETCH.
REQ-025 SHALL, in DRAIN, keep imem_req_o low, drop every rvalid and decrement discard; go to FETCH when discard reaches 0.
REQ-026 SHALL give redirect_i priority over the grant's fpc+4 update and over a same-cycle push.
REQ-027 SHALL handle a further redirect_i during DRAIN by reloading fpc and keeping the remaining discard count.

Reset
REQ-028 SHALL, while rst is high: fpc = RESET_PC; FIFO empty; outstanding = 0; discard = 0; state FETCH; imem_req_o = 0; instr_valid_o = 0; instr_o = 0; pc_o = 0; misalign_o = 0.
REQ-029 SHALL ignore responses to requests issued before a mid-operation reset, counting them as dropped.

Configuration
REQ-030 SHALL, with macro INSTR_FETCH_MISALIGN_TRAP_EN defined, add output misalign_o (1 bit) and state TRAP, entered when redirect_pc_i[1:0] != 0 after draining; in TRAP, misalign_o = 1 and no requests are issued until rst.
REQ-031 SHALL, without INSTR_FETCH_MISALIGN_TRAP_EN, have no misalign_o port, no TRAP state, and force redirect_pc_i[1:0] to 0.

Structure
REQ-032 SHALL place the FSM state enum, the opcode field bit-position constants and the reset constants in the shared package riscv_pkg.
REQ-033 SHALL implement the 2-entry buffer as sub-module fetch_fifo (parameterised width, synchronous flush input).

Verification
REQ-034 SHALL cover: reset release, gnt and rvalid one cycle later, ready = 1 -> addresses 0, 4, 8 issued; pc_o 0, 4, 8; opCode_o = 7'b0110011 for word 32'h0020_81B3.
REQ-035 SHALL cover: instr_ready_i = 0 for 10 cycles -> exactly 2 requests issued, imem_req_o low, FIFO holds pc 0 and 4.
REQ-036 SHALL cover: redirect_i to 32'h100 with 2 requests outstanding -> both rvalids dropped, next request address 32'h100, no stale instr_valid_o.
REQ-037 SHALL cover: redirect_i in the same cycle as a grant -> the grant is counted in discard, fpc = target, not target+4.
REQ-038 SHALL cover: fpc = 32'hFFFF_FFFC, grant -> next request address 0.
REQ-039 SHALL cover, with the macro defined: redirect to 32'h102 -> misalign_o = 1, imem_req_o held low until rst.
